// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix result collector.
// Holds the matrix geometry, the element index type used for bank addressing
// and read-back, and the per-bank state enum.
package matrix_pkg;

    localparam int ROWS  = 3;
    localparam int COLS  = 3;
    localparam int WIDTH = 32;
    localparam int ELEMS = ROWS * COLS;

    // Element index: wide enough for 0..ELEMS-1 plus out-of-range read indices.
    typedef logic [3:0] elem_idx_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

endpackage

// File: rtl/matrix_bank.sv
// One matrix bank: an ELEMS x WIDTH register file.
// Ports:
//   clk, reset       clock, asynchronous active-high reset (clears contents)
//   we, idx, data    write port, element idx <= data when we
//   rdIdx, rdData    indexed read, 0 when rdIdx >= ELEMS
//   flat             all elements, element k at [k*WIDTH +: WIDTH]
module matrix_bank
    import matrix_pkg::*;
#(
    parameter int BW = WIDTH,
    parameter int BN = ELEMS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  elem_idx_t         idx,
    input  logic [BW-1:0]     data,
    input  elem_idx_t         rdIdx,
    output logic [BW-1:0]     rdData,
    output logic [BN*BW-1:0]  flat
);

    localparam elem_idx_t LIMIT = elem_idx_t'(BN);

    logic [BW-1:0] mem [BN];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < BN; k++) begin
                mem[k] <= '0;
            end
        end else if (we) begin
            mem[idx] <= data;
        end
    end

    always_comb begin
        rdData = '0;
        if (rdIdx < LIMIT) begin
            rdData = mem[rdIdx];
        end
    end

    for (genvar k = 0; k < BN; k++) begin : g_flat
        assign flat[k*BW +: BW] = mem[k];
    end

endmodule

// File: rtl/matrix_result_collector.sv
// Matrix result collector: reassembles a row-major element stream into
// complete ROWS x COLS matrices, double-buffered across banks A and B.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   clear                synchronous flush of the partially filled bank
//   eleValid/eleIn       element input, eleReady = room in the fill bank
//   matValid/matReady    output matrix handshake
//   matOut               flat output matrix, 0 while !matValid
//   rdIdx/rdEle          indexed read of the output bank, 0 if out of range
//   matCount             matrices delivered, wraps at 256
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1. Valid never depends on ready; a held matrix (matValid && !matReady)
// keeps matOut stable until it is taken.
module matrix_result_collector
    import matrix_pkg::*;
#(
    parameter int ROWS  = matrix_pkg::ROWS,
    parameter int COLS  = matrix_pkg::COLS,
    parameter int WIDTH = matrix_pkg::WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic                       eleValid,
    input  logic [WIDTH-1:0]           eleIn,
    output logic                       eleReady,
    output logic                       matValid,
    input  logic                       matReady,
    output logic [ROWS*COLS*WIDTH-1:0] matOut,
    input  elem_idx_t                  rdIdx,
    output logic [WIDTH-1:0]           rdEle,
    output logic [7:0]                 matCount
);

    localparam int        NELEM    = ROWS * COLS;
    localparam elem_idx_t LAST_IDX = elem_idx_t'(NELEM - 1);

    logic [1:0]  full;      // bit 0 = bank A, bit 1 = bank B
    logic        fillPtr;   // 0 = A
    logic        outPtr;    // 0 = A
    elem_idx_t   wIdx;

    // Observable per-bank state, derived from the full flags and fill progress.
    bank_state_t bankState [2];

    always_comb begin
        for (int b = 0; b < 2; b++) begin
            bankState[b] = EMPTY;
            if (full[b]) begin
                bankState[b] = FULL;
            end else if ((fillPtr == b[0]) && (wIdx != '0)) begin
                bankState[b] = FILLING;
            end
        end
    end

    assign eleReady = (bankState[fillPtr] != FULL);
    assign matValid = (bankState[outPtr] == FULL);

    // An element coinciding with clear is dropped.
    logic accept, fillDone, pop;
    assign accept   = eleValid && eleReady && !clear;
    assign fillDone = accept && (wIdx == LAST_IDX);
    assign pop      = matValid && matReady;

    // The fill bank is never full and the output bank is always full when
    // popped, so set and clear below always target different banks.
    logic [1:0] setMask, clrMask;
    assign setMask = {fillDone &  fillPtr, fillDone & ~fillPtr};
    assign clrMask = {pop      &  outPtr,  pop      & ~outPtr};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full     <= '0;
            fillPtr  <= 1'b0;
            outPtr   <= 1'b0;
            wIdx     <= '0;
            matCount <= '0;
        end else begin
            full <= (full | setMask) & ~clrMask;
            if (clear) begin
                wIdx <= '0;
            end else if (accept) begin
                if (fillDone) begin
                    wIdx    <= '0;
                    fillPtr <= ~fillPtr;
                end else begin
                    wIdx <= wIdx + elem_idx_t'(1);
                end
            end
            if (pop) begin
                outPtr   <= ~outPtr;
                matCount <= matCount + 8'd1;
            end
        end
    end

    logic [NELEM*WIDTH-1:0] flatA, flatB;
    logic [WIDTH-1:0]       rdA, rdB;

    matrix_bank #(.BW(WIDTH), .BN(NELEM)) bankA (
        .clk    (clk),
        .reset  (reset),
        .we     (accept && !fillPtr),
        .idx    (wIdx),
        .data   (eleIn),
        .rdIdx  (rdIdx),
        .rdData (rdA),
        .flat   (flatA)
    );

    matrix_bank #(.BW(WIDTH), .BN(NELEM)) bankB (
        .clk    (clk),
        .reset  (reset),
        .we     (accept && fillPtr),
        .idx    (wIdx),
        .data   (eleIn),
        .rdIdx  (rdIdx),
        .rdData (rdB),
        .flat   (flatB)
    );

    // Bank contents survive a pop, so outputs are masked while nothing is held.
    assign matOut = matValid ? (outPtr ? flatB : flatA) : '0;
    assign rdEle  = matValid ? (outPtr ? rdB : rdA) : '0;

endmodule

// File: tb/tb_matrix_result_collector.sv
module tb_matrix_result_collector;
    import matrix_pkg::*;

    localparam int W  = 32;
    localparam int N  = 9;
    localparam int MW = W * N;

    typedef logic [MW-1:0] mat_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          clear = 1'b0;
    logic          eleValid = 1'b0;
    logic [W-1:0]  eleIn = '0;
    logic          eleReady;
    logic          matValid;
    logic          matReady = 1'b0;
    mat_t          matOut;
    logic [3:0]    rdIdx = '0;
    logic [W-1:0]  rdEle;
    logic [7:0]    matCount;

    matrix_result_collector dut (
        .clk      (clk),
        .reset    (reset),
        .clear    (clear),
        .eleValid (eleValid),
        .eleIn    (eleIn),
        .eleReady (eleReady),
        .matValid (matValid),
        .matReady (matReady),
        .matOut   (matOut),
        .rdIdx    (rdIdx),
        .rdEle    (rdEle),
        .matCount (matCount)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard / reference model ----------------
    // exp_q holds completed matrices awaiting delivery, oldest first;
    // part_q holds the elements of the matrix currently being assembled.
    int          checks = 0;
    int          errors = 0;
    mat_t        exp_q[$];
    logic [W-1:0] part_q[$];
    logic [7:0]  exp_count = '0;

    logic         obs_ready, obs_valid, obs_acc;
    logic [W-1:0] obs_mat0, obs_mat8, obs_rd;
    mat_t         obs_mat;
    logic [7:0]   obs_cnt;

    task automatic chk(input string name, input mat_t act, input mat_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        part_q.delete();
        exp_count = '0;
    endtask

    // ---------------- driver ----------------
    // Applies one cycle of inputs, compares every output against the model,
    // advances the model, then clocks.
    task automatic cycle(input logic v, input logic [W-1:0] d, input logic r,
                         input logic c, input logic [3:0] idx);
        logic         er, ev;
        mat_t         em, m;
        logic [W-1:0] erd;
        eleValid = v; eleIn = d; matReady = r; clear = c; rdIdx = idx;
        #1;
        er  = (exp_q.size() < 2);
        ev  = (exp_q.size() > 0);
        em  = ev ? exp_q[0] : '0;
        erd = (ev && idx < 4'd9) ? em[idx*W +: W] : '0;
        chk("eleReady", MW'(eleReady), MW'(er));
        chk("matValid", MW'(matValid), MW'(ev));
        chk("matOut",   matOut,        em);
        chk("rdEle",    MW'(rdEle),    MW'(erd));
        chk("matCount", MW'(matCount), MW'(exp_count));
        obs_ready = eleReady; obs_valid = matValid; obs_mat = matOut;
        obs_mat0 = matOut[W-1:0]; obs_mat8 = matOut[MW-1 -: W];
        obs_rd = rdEle; obs_cnt = matCount;
        obs_acc = v && eleReady && !c;
        // model update
        if (c) begin
            part_q.delete();
        end else if (v && er) begin
            part_q.push_back(d);
            if (part_q.size() == N) begin
                m = '0;
                for (int k = 0; k < N; k++) m[k*W +: W] = part_q[k];
                part_q.delete();
                exp_q.push_back(m);
            end
        end
        if (ev && r) begin
            void'(exp_q.pop_front());
            exp_count = exp_count + 8'd1;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic         v;
        logic [W-1:0] d;
        logic         r;
        logic [3:0]   idx;
        logic         e_ready;
        logic         e_valid;
        logic [W-1:0] e_rd;
        logic [W-1:0] e_m0;
        logic [W-1:0] e_m8;
        logic [7:0]   e_cnt;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int k, budget, pops;

        // ---- reset, asserted asynchronously between edges ----
        #3 reset = 1'b1;
        #1;
        chk("rst_eleReady", MW'(eleReady), MW'(1));
        chk("rst_matValid", MW'(matValid), MW'(0));
        chk("rst_matOut",   matOut,        '0);
        chk("rst_matCount", MW'(matCount), MW'(0));
        chk("rst_rdEle",    MW'(rdEle),    MW'(0));
        #3 reset = 1'b0;
        model_reset();
        @(posedge clk); #1;

        // ---- single matrix, table driven ----
        for (int i = 0; i < 9; i++)
            tbl[i] = '{1'b1, W'(i + 1), 1'b1, 4'd4, 1'b1, 1'b0, '0, '0, '0, 8'd0};
        tbl[9]  = '{1'b0, '0, 1'b0, 4'd4,  1'b1, 1'b1, 32'd5, 32'd1, 32'd9, 8'd0};
        tbl[10] = '{1'b0, '0, 1'b0, 4'd12, 1'b1, 1'b1, 32'd0, 32'd1, 32'd9, 8'd0};
        tbl[11] = '{1'b0, '0, 1'b1, 4'd0,  1'b1, 1'b1, 32'd1, 32'd1, 32'd9, 8'd0};
        tbl[12] = '{1'b0, '0, 1'b0, 4'd0,  1'b1, 1'b0, 32'd0, 32'd0, 32'd0, 8'd1};
        for (int i = 0; i < 13; i++) begin
            cycle(tbl[i].v, tbl[i].d, tbl[i].r, 1'b0, tbl[i].idx);
            chk($sformatf("tbl%0d_ready", i), MW'(obs_ready), MW'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_valid", i), MW'(obs_valid), MW'(tbl[i].e_valid));
            chk($sformatf("tbl%0d_rdEle", i), MW'(obs_rd),    MW'(tbl[i].e_rd));
            chk($sformatf("tbl%0d_m0", i),    MW'(obs_mat0),  MW'(tbl[i].e_m0));
            chk($sformatf("tbl%0d_m8", i),    MW'(obs_mat8),  MW'(tbl[i].e_m8));
            chk($sformatf("tbl%0d_cnt", i),   MW'(obs_cnt),   MW'(tbl[i].e_cnt));
        end

        // ---- backpressure: 18 fill both banks, 19th waits ----
        k = 1; budget = 40;
        while (k <= 18 && budget > 0) begin
            cycle(1'b1, W'(k), 1'b0, 1'b0, 4'd0);
            if (obs_acc) k++;
            budget--;
        end
        if (budget == 0) begin
            errors++; checks++;
            $display("FAIL bp_fill: accepted %0d elements, required 18", k - 1);
        end
        cycle(1'b1, 32'd19, 1'b0, 1'b0, 4'd0);
        chk("bp_ready_low1", MW'(obs_ready), MW'(0));
        cycle(1'b1, 32'd19, 1'b0, 1'b0, 4'd0);
        chk("bp_ready_low2", MW'(obs_ready), MW'(0));
        cycle(1'b1, 32'd19, 1'b1, 1'b0, 4'd0);
        chk("bp_first_m0",  MW'(obs_mat0),  MW'(1));
        chk("bp_pop_ready", MW'(obs_ready), MW'(0));
        cycle(1'b1, 32'd19, 1'b1, 1'b0, 4'd0);
        chk("bp_second_m0", MW'(obs_mat0),  MW'(10));
        chk("bp_ready_back", MW'(obs_ready), MW'(1));
        cycle(1'b0, '0, 1'b1, 1'b0, 4'd0);
        chk("bp_drained", MW'(obs_valid), MW'(0));
        chk("bp_count",   MW'(obs_cnt),   MW'(3));

        // ---- clear: partial discarded, coincident element dropped ----
        // 19 is still pending in the fill bank; clear drops it too.
        for (int i = 0; i < 4; i++) cycle(1'b1, W'(50 + i), 1'b0, 1'b0, 4'd0);
        cycle(1'b1, 32'd99, 1'b0, 1'b1, 4'd0);
        for (int i = 0; i < 9; i++) cycle(1'b1, W'(100 + i), 1'b0, 1'b0, 4'd0);
        cycle(1'b0, '0, 1'b0, 1'b0, 4'd0);
        chk("clr_valid", MW'(obs_valid), MW'(1));
        for (int i = 0; i < 9; i++)
            chk($sformatf("clr_e%0d", i), MW'(obs_mat[i*W +: W]), MW'(100 + i));
        cycle(1'b0, '0, 1'b1, 1'b0, 4'd0);

        // ---- simultaneous fill-complete of B and pop of A ----
        for (int i = 1; i <= 9; i++) cycle(1'b1, W'(i), 1'b0, 1'b0, 4'd0);
        for (int i = 11; i <= 18; i++) cycle(1'b1, W'(i), 1'b0, 1'b0, 4'd0);
        cycle(1'b1, 32'd19, 1'b1, 1'b0, 4'd0);
        chk("sim_valid", MW'(obs_valid), MW'(1));
        chk("sim_m0_a",  MW'(obs_mat0),  MW'(1));
        chk("sim_acc",   MW'(obs_acc),   MW'(1));
        cycle(1'b0, '0, 1'b0, 1'b0, 4'd0);
        chk("sim_valid2", MW'(obs_valid), MW'(1));
        chk("sim_m0_b",   MW'(obs_mat0),  MW'(11));
        chk("sim_ready",  MW'(obs_ready), MW'(1));
        cycle(1'b0, '0, 1'b1, 1'b0, 4'd0);

        // ---- reset mid-stream with held and partial matrices ----
        for (int i = 0; i < 12; i++) cycle(1'b1, $urandom, 1'b0, 1'b0, 4'd0);
        eleValid = 1'b0; matReady = 1'b0; clear = 1'b0; rdIdx = 4'd0;
        #2 reset = 1'b1;
        #1;
        chk("mrst_eleReady", MW'(eleReady), MW'(1));
        chk("mrst_matValid", MW'(matValid), MW'(0));
        chk("mrst_matOut",   matOut,        '0);
        chk("mrst_matCount", MW'(matCount), MW'(0));
        model_reset();
        #1 reset = 1'b0;
        @(posedge clk); #1;

        // ---- wrap: 256 matrices at full throughput ----
        pops = 0; budget = 3000;
        while (pops < 256 && budget > 0) begin
            cycle(1'b1, $urandom, 1'b1, 1'b0, 4'($urandom_range(0, 15)));
            if (obs_valid) pops++;
            budget--;
        end
        if (pops < 256) begin
            errors++; checks++;
            $display("FAIL wrap_budget: delivered %0d matrices, required 256", pops);
        end
        cycle(1'b0, '0, 1'b0, 1'b0, 4'd0);
        chk("wrap_count", MW'(obs_cnt), MW'(0));

        // ---- randomized traffic against the model ----
        for (int i = 0; i < 2500; i++)
            cycle($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0,
                  $urandom_range(0, 40) == 0, 4'($urandom_range(0, 15)));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/matrix_result_collector.md
# matrix_result_collector

Receive-side companion to the matrix ALU datapath. Consumes the 32-bit element stream produced by the ALU, reassembles each run of nine elements (row-major) into a complete 3x3 result matrix, and holds it for the downstream consumer. The consumer takes the matrix through a valid/ready handshake on a flat bus or by indexed reads. Double-buffered, so the ALU can stream back-to-back matrices while the consumer drains the previous one.

## Interface
- ROWS, 3, matrix rows
- COLS, 3, matrix columns
- WIDTH, 32, element width in bits
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- clear  in  1  synchronous flush of the partially filled bank
- eleValid  in  1  element strobe from ALU side
- eleIn  in  WIDTH  element data, row-major order
- eleReady  out  1  collector can accept an element this cycle
- matValid  out  1  a complete matrix is held in the output bank
- matReady  in  1  consumer accepts the output matrix
- matOut  out  ROWS*COLS*WIDTH  element k at bits [k*WIDTH +: WIDTH]
- rdIdx  in  4  element index for random-access read of the output bank
- rdEle  out  WIDTH  element rdIdx of the output bank; 0 if rdIdx ≥ 9 or !matValid
- matCount  out  8  matrices delivered, wraps 255→0

## Operation
- Two banks, A and B, each nine elements, with a full flag per bank, a fill pointer (bank select), an output pointer (bank select), and a 4-bit element index wIdx.
- Accept: eleValid && eleReady → write eleIn to fill bank [wIdx], wIdx++.
  - At wIdx = 8: set the bank's full flag, set wIdx = 0, toggle the fill pointer.
- eleReady = !full[fill bank]. eleReady is 1 when at least one bank is free.
- matValid = full[output bank].
- Pop: matValid && matReady → clear full[output bank], toggle the output pointer, matCount++.
- Simultaneous fill-complete and pop are both honoured in the same cycle. The banks are distinct, so there is no conflict.
- clear: sets wIdx = 0 and discards partial contents. Full banks are untouched. If eleValid coincides with clear, the element is dropped.
- Bank data is not zeroed on pop. The outputs matOut and rdEle read as 0 while matValid = 0.
- State per bank: EMPTY → FILLING (first element) → FULL (ninth element) → EMPTY (pop). FILLING → EMPTY on clear.

## Timing
- Reset values: eleReady = 1, matValid = 0, matOut = 0, rdEle = 0, matCount = 0, wIdx = 0, both banks EMPTY, both pointers at A.
- Reset mid-stream aborts the partial matrix and any held matrices. No output is produced for them.
- Latency: ninth element accepted in cycle N → matValid = 1 and matOut valid in cycle N+1.
- rdEle is combinational from rdIdx and registered bank contents, with zero added latency.
- Throughput: with matReady held at 1, one element per cycle is sustained indefinitely and eleReady never drops.
- Backpressure: with matReady = 0, after 18 accepted elements both banks are FULL and eleReady = 0 from the next cycle. eleReady returns to 1 the cycle after a pop.
- matOut and matValid are stable while matValid && !matReady. Matrices are delivered strictly in arrival order.

## Structure
- Shared package matrix_pkg holds:
  - constants ROWS, COLS, WIDTH and ELEMS = ROWS*COLS;
  - element index type (4 bits);
  - bank-state enum {EMPTY, FILLING, FULL}.
- Natural sub-module: matrix_bank, one 9×WIDTH register file with a write port (we, idx, data), a flat read bus, and an indexed read. It is instantiated twice.
- Top level holds the pointers, wIdx, the full flags, the handshake logic and matCount.

## Test plan
- Reset: assert reset asynchronously mid-cycle → outputs read eleReady = 1, matValid = 0, matOut = 0 and matCount = 0 immediately, without waiting for a clock edge.
- Single matrix: stream 1..9, matReady = 1 → matValid high one cycle after the ninth element, with matOut[31:0] = 1 and matOut[287:256] = 9. Reading rdIdx = 4 gives rdEle = 5, and rdIdx = 12 gives 0. matCount = 1 after the pop.
- Backpressure: matReady = 0, offer 19 elements (1..19) → eleReady drops after the 18th and the 19th is held. Raising matReady delivers the matrix with element 0 = 1, then the matrix with element 0 = 10, then 19 is accepted.
- Clear: accept 4 elements, pulse clear, then stream 100..108 → the delivered matrix is exactly 100..108.
- Simultaneous events: the last element of bank B is accepted in the same cycle bank A pops → no stall cycle, matValid stays 1, and matOut switches to bank B on the next cycle.
- Wrap: deliver 256 matrices → matCount returns to 0, with no data corruption.
